pcie_switch_n: RTL and testbench
================================

PCIE_SWITCH_N -- requirements
Module: pcie_switch_n

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of classes and the number of destinations (power of 2, 2..8).
REQ-002 The block SHALL have parameter DATA_W, default 12, giving the word width.
REQ-003 The block SHALL have parameter DEPTH, default 8, giving the entries per FIFO (power of 2).
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the per-destination counter width.
REQ-005 The block SHALL use derived widths CLS_W = log2(N_CH) and TH_W = log2(DEPTH)+1.
REQ-006 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- init  in  1  threshold-programming request
- umbral_L  in  TH_W  almost-empty threshold
- umbral_H  in  TH_W  almost-full threshold
- push  in  1  input word valid
- data_in  in  DATA_W  class = data_in[DATA_W-1 -: CLS_W]; dest = next CLS_W bits down
- in_full  out  1  class FIFO selected by data_in is full
- pop  in  N_CH  consumer pop, one bit per destination
- data_out  out  N_CH*DATA_W  destination heads; slice i = destination i
- empty  out  N_CH  destination FIFO empty
- almost_empty  out  N_CH  destination count <= umbral_L
- req  in  1  counter read request
- idx  in  CLS_W  counter select
- cnt_data  out  CNT_W  counter value
- cnt_valid  out  1  cnt_data valid
- idle  out  1  FSM in IDLE
- error  out  1  sticky overflow/underflow flag

Function
REQ-007 The block SHALL contain N_CH class FIFOs and N_CH destination FIFOs, all first-word-fall-through with head valid while not empty.
REQ-008 A push with the selected class FIFO not full SHALL write data_in into class FIFO[class]; the word SHALL be visible at the head one cycle later.
REQ-009 A push to a full class FIFO SHALL drop the word and set error.
REQ-010 Each cycle the arbiter SHALL grant at most one class FIFO; a class is eligible when it is non-empty and destination FIFO[dest of head] has count < latched umbral_H.
REQ-011 Grant SHALL be round-robin, searching from (last granted + 1) mod N_CH; the last-granted pointer resets to N_CH-1, so class 0 has first priority.
REQ-012 A grant SHALL pop the class head and push it into its destination FIFO in the same cycle; minimum input-to-data_out latency is 2 cycles.
REQ-013 Arbitration SHALL occur only in states IDLE and ACTIVE.
REQ-014 Simultaneous arbiter push and consumer pop on one destination FIFO SHALL both take effect, leaving count unchanged.
REQ-015 A pop on an empty destination FIFO SHALL be ignored and SHALL set error.
REQ-016 Pointers SHALL wrap modulo DEPTH, and full/empty SHALL be distinguished by a count of TH_W bits.
REQ-017 FSM states and transitions:
- RESET -> INIT after reset is released.
- INIT -> IDLE when init=0.
- IDLE -> ACTIVE when any FIFO is non-empty.
- ACTIVE -> IDLE when all FIFOs are empty.
- IDLE or ACTIVE -> INIT when init=1; FIFO contents are held.
REQ-018 In INIT, the block SHALL latch umbral_L/umbral_H each cycle only if umbral_L < umbral_H <= DEPTH-1; otherwise the previous values SHALL be kept.
REQ-019 Each destination counter SHALL increment on every accepted consumer pop and SHALL wrap at 2^CNT_W.
REQ-020 When req=1 in IDLE, the block SHALL drive cnt_data = counter[idx] and cnt_valid = 1 on the next cycle; otherwise cnt_valid SHALL be 0 and cnt_data SHALL hold.

Reset
REQ-021 Reset SHALL clear:
- All FIFO pointers and counts, so empty is all ones and in_full = 0.
- All counters, cnt_data, cnt_valid and error.
- The arbiter pointer, to N_CH-1.
REQ-022 Reset SHALL set the FSM to RESET and idle = 0, and set latched thresholds to L=1 and H=DEPTH-1.
REQ-023 A reset asserted mid-transfer SHALL discard all stored words in the same clock edge.

Structure
REQ-024 The FSM state encoding and the field-position constants for class/dest SHALL live in a shared package, pcie_pkg.
REQ-025 A single parametrised FIFO sub-module, fifo_fwft (DATA_W, DEPTH, exposing count), SHALL be instantiated 2*N_CH times; the arbiter, FSM and counters SHALL be inline.

Verification
REQ-026 After reset and INIT with L=2, H=6, push 0x100 (class 0, dest 1) -> data_out slice 1 = 0x100 and empty[1] = 0 two cycles after the push.
REQ-027 With classes 0..3 pre-loaded and all eligible -> grants go 0,1,2,3,0 on consecutive cycles.
REQ-028 Fill destination 2 to count 6 with H=6 and no pops -> no further grants to words for dest 2 while other destinations continue; one pop[2] resumes flow next cycle.
REQ-029 Nine pushes of class 3 with arbitration stalled (dest full) -> in_full = 1 after the 8th push and error = 1 after the 9th; error stays set until reset.
REQ-030 Pop destination 0 five times, then return to IDLE, req=1 with idx=0 -> cnt_valid = 1 and cnt_data = 5 the next cycle.
REQ-031 Load umbral_L=5, umbral_H=3 in INIT -> thresholds remain 1/7.

Source files
------------

// File: rtl/pcie_pkg.sv
// pcie_pkg: shared FSM encoding and data-word field positions for pcie_switch_n
package pcie_pkg;
    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE} state_t;
    function automatic int cls_msb(input int data_w);
        return data_w - 1;
    endfunction
    function automatic int dst_msb(input int data_w, input int cls_w);
        return data_w - 1 - cls_w;
    endfunction
endpackage

// File: rtl/pcie_switch_n_fifo.sv
// fifo_fwft: first-word-fall-through FIFO; head valid while count != 0
// ports: clk, reset (sync, high), wr/din push, rd pop, dout head, count occupancy
module fifo_fwft #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr,
    input  logic [DATA_W-1:0]      din,
    input  logic                   rd,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_wr, do_rd;
    assign do_wr = wr && count != (AW+1)'(DEPTH);
    assign do_rd = rd && count != '0;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(do_wr);
            rp <= rp + AW'(do_rd);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/pcie_switch_n.sv
// pcie_switch_n: class-to-destination word switch with round-robin arbiter
// ports: clk, reset; init/umbral_L/umbral_H threshold programming; push/data_in/in_full input side;
// pop/data_out/empty/almost_empty destination side; req/idx/cnt_data/cnt_valid pop counters; idle, error
module pcie_switch_n
    import pcie_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [$clog2(DEPTH):0]   umbral_L,
    input  logic [$clog2(DEPTH):0]   umbral_H,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     in_full,
    input  logic [N_CH-1:0]          pop,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          empty,
    output logic [N_CH-1:0]          almost_empty,
    input  logic                     req,
    input  logic [$clog2(N_CH)-1:0]  idx,
    output logic [CNT_W-1:0]         cnt_data,
    output logic                     cnt_valid,
    output logic                     idle,
    output logic                     error
);
    localparam int CLS_W = $clog2(N_CH);
    localparam int TH_W = $clog2(DEPTH) + 1;
    localparam int CLS_MSB = cls_msb(DATA_W);
    localparam int DST_MSB = dst_msb(DATA_W, CLS_W);
    state_t state, state_nx;
    logic [DATA_W-1:0] cf_dout [N_CH];
    logic [TH_W-1:0] cf_count [N_CH];
    logic [TH_W-1:0] df_count [N_CH];
    logic [CLS_W-1:0] head_dst [N_CH];
    logic [N_CH-1:0] cf_full, cf_empty, cf_wr, cf_rd, df_wr, pop_ok, elig;
    logic [CLS_W-1:0] cls_in, last, gnt;
    logic [DATA_W-1:0] gnt_word;
    logic [TH_W-1:0] th_l, th_h;
    logic [CNT_W-1:0] cnt [N_CH];
    logic gnt_vld, arb_en, any_ne;
    assign cls_in = data_in[CLS_MSB -: CLS_W];
    assign in_full = cf_full[cls_in];
    assign gnt_word = cf_dout[gnt];
    assign any_ne = !(&cf_empty && &empty);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cf (
            .clk(clk), .reset(reset), .wr(cf_wr[i]), .din(data_in), .rd(cf_rd[i]),
            .dout(cf_dout[i]), .count(cf_count[i])
        );
        fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_df (
            .clk(clk), .reset(reset), .wr(df_wr[i]), .din(gnt_word), .rd(pop_ok[i]),
            .dout(data_out[i*DATA_W +: DATA_W]), .count(df_count[i])
        );
        assign cf_empty[i] = cf_count[i] == '0;
        assign cf_full[i] = cf_count[i] == TH_W'(DEPTH);
        assign empty[i] = df_count[i] == '0;
        assign almost_empty[i] = df_count[i] <= th_l;
        assign head_dst[i] = cf_dout[i][DST_MSB -: CLS_W];
        assign elig[i] = arb_en && !cf_empty[i] && df_count[head_dst[i]] < th_h;
        assign cf_wr[i] = push && cls_in == CLS_W'(i) && !cf_full[i];
        assign cf_rd[i] = gnt_vld && gnt == CLS_W'(i);
        assign df_wr[i] = gnt_vld && head_dst[gnt] == CLS_W'(i);
        assign pop_ok[i] = pop[i] && !empty[i];
    end
    // Scan downward so the candidate nearest to last+1 wins; k=N_CH wraps to last itself.
    always_comb begin
        gnt_vld = 1'b0;
        gnt = last;
        for (int k = N_CH; k >= 1; k--)
            if (elig[last + CLS_W'(k)]) begin
                gnt_vld = 1'b1;
                gnt = last + CLS_W'(k);
            end
    end
    always_comb begin
        state_nx = state;
        idle = state == ST_IDLE;
        arb_en = state == ST_IDLE || state == ST_ACTIVE;
        case (state)
            ST_RESET:  state_nx = ST_INIT;
            ST_INIT:   state_nx = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_nx = init ? ST_INIT : any_ne ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_nx = init ? ST_INIT : any_ne ? ST_ACTIVE : ST_IDLE;
            default:   state_nx = ST_RESET;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
            last <= CLS_W'(N_CH - 1);
            th_l <= TH_W'(1);
            th_h <= TH_W'(DEPTH - 1);
            cnt <= '{default: '0};
            cnt_data <= '0;
            cnt_valid <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nx;
            if (gnt_vld) last <= gnt;
            if (state == ST_INIT && umbral_L < umbral_H && umbral_H <= TH_W'(DEPTH - 1)) begin
                th_l <= umbral_L;
                th_h <= umbral_H;
            end
            for (int i = 0; i < N_CH; i++)
                if (pop_ok[i]) cnt[i] <= cnt[i] + CNT_W'(1);
            cnt_valid <= req && idle;
            if (req && idle) cnt_data <= cnt[idx];
            if ((push && in_full) || |(pop & empty)) error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pcie_switch_n.sv
// tb_pcie_switch_n: vector table, directed corner sequences and queue-model random checking
module tb_pcie_switch_n;
    logic clk = 1'b0;
    logic reset = 1'b1, init = 1'b0, push = 1'b0, req = 1'b0;
    logic [3:0] umbral_L = 4'd1, umbral_H = 4'd7, pop = 4'd0;
    logic [11:0] data_in = 12'd0;
    logic [1:0] idx = 2'd0;
    logic in_full, cnt_valid, idle, error;
    logic [47:0] data_out;
    logic [3:0] empty, almost_empty;
    logic [7:0] cnt_data;
    typedef logic [11:0] wq_t [$];
    wq_t qc [4];
    wq_t qd [4];
    int mst, thl, thh, mlast, mcd;
    int mcnt [4];
    bit mcv, merr;
    int checks = 0, failures = 0;
    typedef struct {
        logic rst, ini, psh;
        logic [11:0] d;
        logic [3:0] ul, uh;
        logic chk_d1;
        logic [3:0] e_empty;
        logic e_idle;
        logic [11:0] e_d1;
    } vec_t;
    vec_t tv [7];

    pcie_switch_n #(.N_CH(4), .DATA_W(12), .DEPTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .init(init), .umbral_L(umbral_L), .umbral_H(umbral_H),
        .push(push), .data_in(data_in), .in_full(in_full), .pop(pop), .data_out(data_out),
        .empty(empty), .almost_empty(almost_empty), .req(req), .idx(idx),
        .cnt_data(cnt_data), .cnt_valid(cnt_valid), .idle(idle), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int g;
        bit busy;
        logic [11:0] w;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                qc[i].delete();
                qd[i].delete();
                mcnt[i] = 0;
            end
            mst = 0; thl = 1; thh = 7; mlast = 3; mcd = 0; mcv = 0; merr = 0;
            return;
        end
        busy = 0;
        g = -1;
        for (int i = 0; i < 4; i++) if (qc[i].size() > 0 || qd[i].size() > 0) busy = 1;
        if (mst >= 2)
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (mlast + k) % 4;
                if (g < 0 && qc[c].size() > 0) begin
                    w = qc[c][0];
                    if (qd[w[9:8]].size() < thh) g = c;
                end
            end
        mcv = req && mst == 2;
        if (mcv) mcd = mcnt[idx];
        for (int i = 0; i < 4; i++)
            if (pop[i]) begin
                if (qd[i].size() > 0) begin
                    void'(qd[i].pop_front());
                    mcnt[i] = (mcnt[i] + 1) % 256;
                end else merr = 1;
            end
        if (push) begin
            if (qc[data_in[11:10]].size() == 8) merr = 1;
            else qc[data_in[11:10]].push_back(data_in);
        end
        if (g >= 0) begin
            w = qc[g].pop_front();
            qd[w[9:8]].push_back(w);
            mlast = g;
        end
        if (mst == 1 && umbral_L < umbral_H && umbral_H <= 4'd7) begin
            thl = int'(umbral_L);
            thh = int'(umbral_H);
        end
        mst = mst == 0 ? 1 : init ? 1 : mst == 1 ? 2 : busy ? 3 : 2;
    endtask

    task automatic compare();
        logic [11:0] h;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("empty[%0d]", i), empty[i], qd[i].size() == 0);
            chk($sformatf("almost_empty[%0d]", i), almost_empty[i], qd[i].size() <= thl);
            if (qd[i].size() > 0) begin
                h = qd[i][0];
                chk($sformatf("data_out[%0d]", i), data_out[i*12 +: 12], h);
            end
        end
        chk("idle", idle, mst == 2);
        chk("error", error, merr);
        chk("cnt_valid", cnt_valid, mcv);
        chk("cnt_data", cnt_data, mcd);
    endtask

    task automatic tick();
        if (!reset) chk("in_full", in_full, qc[data_in[11:10]].size() == 8);
        model_step();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_w(input logic [11:0] w);
        push = 1'b1;
        data_in = w;
        tick();
        push = 1'b0;
    endtask

    task automatic start(input logic [3:0] ul, input logic [3:0] uh);
        reset = 1'b1; init = 1'b0; push = 1'b0; pop = 4'd0; req = 1'b0;
        tick();
        reset = 1'b0; init = 1'b1; umbral_L = ul; umbral_H = uh;
        run(2);
        init = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] exp_e [5];
        logic [3:0] exp_ae [5];
        int n, ictr;
        exp_e = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        exp_ae = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1110};
        tv[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 4'd2, 4'd6, 1'b0, 4'hF, 1'b0, 12'h000};
        tv[1] = '{1'b0, 1'b1, 1'b0, 12'h000, 4'd2, 4'd6, 1'b0, 4'hF, 1'b0, 12'h000};
        tv[2] = '{1'b0, 1'b1, 1'b0, 12'h000, 4'd2, 4'd6, 1'b0, 4'hF, 1'b0, 12'h000};
        tv[3] = '{1'b0, 1'b0, 1'b0, 12'h000, 4'd2, 4'd6, 1'b0, 4'hF, 1'b1, 12'h000};
        tv[4] = '{1'b0, 1'b0, 1'b1, 12'h100, 4'd2, 4'd6, 1'b0, 4'hF, 1'b1, 12'h000};
        tv[5] = '{1'b0, 1'b0, 1'b0, 12'h000, 4'd2, 4'd6, 1'b1, 4'hD, 1'b0, 12'h100};
        tv[6] = '{1'b0, 1'b0, 1'b0, 12'h000, 4'd2, 4'd6, 1'b1, 4'hD, 1'b0, 12'h100};
        @(negedge clk);
        for (int r = 0; r < 7; r++) begin
            reset = tv[r].rst; init = tv[r].ini; push = tv[r].psh; data_in = tv[r].d;
            umbral_L = tv[r].ul; umbral_H = tv[r].uh;
            tick();
            chk($sformatf("tv%0d empty", r), empty, tv[r].e_empty);
            chk($sformatf("tv%0d idle", r), idle, tv[r].e_idle);
            if (tv[r].chk_d1) chk($sformatf("tv%0d data_out[1]", r), data_out[23:12], tv[r].e_d1);
        end
        push = 1'b0;

        reset = 1'b1; tick();
        reset = 1'b0; init = 1'b1; umbral_L = 4'd1; umbral_H = 4'd7; tick();
        push_w(12'h001); push_w(12'h002); push_w(12'h503); push_w(12'hA04); push_w(12'hF05);
        init = 1'b0; tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d empty", k), empty, exp_e[k]);
            chk($sformatf("rr%0d almost_empty", k), almost_empty, exp_ae[k]);
        end

        start(4'd2, 4'd6);
        for (int k = 0; k < 8; k++) push_w(12'hA00 | 12'(k));
        run(3);
        push_w(12'h5AA);
        tick();
        chk("stall other dest empty[1]", empty[1], 1'b0);
        chk("stall other dest data", data_out[23:12], 12'h5AA);
        chk("stall dest2 empty", empty[2], 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("resume head %0d", k), data_out[35:24], 12'hA00 | 12'(k));
            pop = 4'b0100;
            tick();
            pop = 4'd0;
        end

        start(4'd1, 4'd7);
        for (int k = 0; k < 7; k++) push_w(12'hF00 | 12'(k));
        run(2);
        for (int k = 1; k <= 9; k++) begin
            push = 1'b1;
            data_in = 12'hF10 | 12'(k);
            if (k == 8) chk("in_full before 8th", in_full, 1'b0);
            tick();
            if (k == 8) chk("in_full after 8th", in_full, 1'b1);
            if (k == 8) chk("error after 8th", error, 1'b0);
            if (k == 9) chk("error after 9th", error, 1'b1);
        end
        push = 1'b0;
        pop = 4'b1000;
        run(3);
        pop = 4'd0;
        chk("error sticky", error, 1'b1);

        start(4'd1, 4'd7);
        for (int k = 1; k <= 5; k++) push_w(12'(k));
        run(3);
        pop = 4'b0001;
        run(5);
        pop = 4'd0;
        n = 0;
        while (!idle && n < 50) begin
            tick();
            n++;
        end
        chk("reach idle", idle, 1'b1);
        req = 1'b1; idx = 2'd0;
        tick();
        req = 1'b0;
        chk("cnt_valid read", cnt_valid, 1'b1);
        chk("cnt_data read", cnt_data, 8'd5);
        tick();
        chk("cnt_valid drop", cnt_valid, 1'b0);
        chk("cnt_data hold", cnt_data, 8'd5);

        start(4'd5, 4'd3);
        for (int k = 0; k < 15; k++) push_w(12'(k));
        chk("bad thr in_full", in_full, 1'b1);
        chk("bad thr error", error, 1'b0);
        tick();
        chk("bad thr almost_empty[0]", almost_empty[0], 1'b0);

        start(4'd1, 4'd7);
        ictr = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 499) == 0;
            if ($urandom_range(0, 59) == 0) ictr = $urandom_range(1, 4);
            init = ictr > 0;
            if (ictr > 0) ictr--;
            umbral_L = 4'($urandom_range(0, 7));
            umbral_H = 4'($urandom_range(0, 8));
            push = $urandom_range(0, 1) == 1;
            data_in = 12'($urandom);
            for (int i = 0; i < 4; i++)
                pop[i] = qd[i].size() > 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 99) == 0;
            req = $urandom_range(0, 3) == 0;
            idx = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0; push = 1'b0; pop = 4'd0; req = 1'b0; init = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
